lcd_ctrl: RTL

Character-LCD write engine (HD44780-compatible, 8-bit parallel bus, write-only) driven by the core's LCD output port. Accepts one command or data byte per valid/ready handshake. Generates the bus timing: setup, enable pulse, hold and execution wait. After reset it runs a power-on wait and a fixed init sequence, then reports ready.

---
 rtl/lcd_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style character LCD write engine (8-bit bus, write-only).
// After reset it optionally waits POR_CYC cycles and writes a fixed four-entry
// init sequence, then accepts one command/data byte per valid/ready handshake.
// Each write runs SETUP -> EN_HI -> HOLD -> EXEC with cycle counts set by the
// parameters. All outputs come straight from flops, so EN cannot glitch.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   cmd_valid_i  command request
//   cmd_rs_i     0 = instruction, 1 = data
//   cmd_data_i   byte to write
//   cmd_ready_o  engine can accept a command (IDLE and init complete)
//   init_done_o  init sequence complete, sticky until reset
//   lcd_on_o     LCD power enable
//   lcd_rs_o     LCD register select
//   lcd_rw_o     LCD read/write, always 0 (write)
//   lcd_en_o     LCD enable strobe
//   lcd_data_o   LCD data bus
module lcd_ctrl #(
  parameter int unsigned INIT_EN       = 1,
  parameter int unsigned POR_CYC       = 2000000,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2500,
  parameter int unsigned LONG_EXEC_CYC = 82000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  // Counter reload values: a state lasting N cycles loads N-1; zero counts as one.
  localparam logic [31:0] PorLd      = (POR_CYC == 0)       ? 32'd0 : POR_CYC - 1;
  localparam logic [31:0] SetupLd    = (SETUP_CYC == 0)     ? 32'd0 : SETUP_CYC - 1;
  localparam logic [31:0] EnLd       = (EN_CYC == 0)        ? 32'd0 : EN_CYC - 1;
  localparam logic [31:0] HoldLd     = (HOLD_CYC == 0)      ? 32'd0 : HOLD_CYC - 1;
  localparam logic [31:0] ExecLd     = (EXEC_CYC == 0)      ? 32'd0 : EXEC_CYC - 1;
  localparam logic [31:0] LongExecLd = (LONG_EXEC_CYC == 0) ? 32'd0 : LONG_EXEC_CYC - 1;
  localparam bit          InitOn     = (INIT_EN != 0);

  // The INIT phase has no state of its own: it is the WRITE sequence run with
  // r_init_busy set, so POR_WAIT and each EXEC step straight into the next SETUP.
  typedef enum logic [2:0] {
    StPorWait,
    StIdle,
    StSetup,
    StEnHi,
    StHold,
    StExec
  } state_e;

  state_e      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_idx;
  logic        r_init_busy;
  logic        r_ready;
  logic        r_init_done;
  logic        r_lcd_on;
  logic        r_rs;
  logic        r_en;
  logic [7:0]  r_data;

  logic        w_cnt_zero;
  logic        w_long_exec;
  logic        w_take;
  logic        w_done_nxt;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] val;
    unique case (idx)
      2'd0:    val = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    val = 8'h0C;  // display on, cursor off
      2'd2:    val = 8'h01;  // clear display
      default: val = 8'h06;  // entry mode: increment, no shift
    endcase
    return val;
  endfunction

  assign w_cnt_zero  = (r_cnt == 32'd0);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign w_long_exec = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));
  assign w_take      = cmd_valid_i && r_ready;
  assign w_done_nxt  = r_init_done || !InitOn;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= InitOn ? StPorWait : StIdle;
      r_cnt       <= InitOn ? PorLd : 32'd0;
      r_idx       <= 2'd0;
      r_init_busy <= InitOn;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_lcd_on    <= 1'b0;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_lcd_on <= 1'b1;
      case (r_state)
        StPorWait: begin
          if (w_cnt_zero) begin
            r_state <= StSetup;
            r_cnt   <= SetupLd;
            r_idx   <= 2'd0;
            r_rs    <= 1'b0;
            r_data  <= init_rom(2'd0);
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        StIdle: begin
          r_init_done <= w_done_nxt;
          if (w_take) begin
            r_state <= StSetup;
            r_cnt   <= SetupLd;
            r_rs    <= cmd_rs_i;
            r_data  <= cmd_data_i;
            r_ready <= 1'b0;
          end else begin
            r_ready <= w_done_nxt;
          end
        end
        StSetup: begin
          if (w_cnt_zero) begin
            r_state <= StEnHi;
            r_cnt   <= EnLd;
            r_en    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        StEnHi: begin
          if (w_cnt_zero) begin
            r_state <= StHold;
            r_cnt   <= HoldLd;
            r_en    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        StHold: begin
          if (w_cnt_zero) begin
            r_state <= StExec;
            r_cnt   <= w_long_exec ? LongExecLd : ExecLd;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        StExec: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 32'd1;
          end else if (r_init_busy && (r_idx != 2'd3)) begin
            r_state <= StSetup;
            r_cnt   <= SetupLd;
            r_idx   <= r_idx + 2'd1;
            r_rs    <= 1'b0;
            r_data  <= init_rom(r_idx + 2'd1);
          end else begin
            // Ready is raised here so it is high on the first IDLE cycle.
            r_state     <= StIdle;
            r_init_busy <= 1'b0;
            r_init_done <= 1'b1;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign init_done_o = r_init_done;
  assign lcd_on_o    = r_lcd_on;
  assign lcd_rs_o    = r_rs;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = r_en;
  assign lcd_data_o  = r_data;

endmodule
